button_pulse_conditioner: RTL and testbench
===========================================

// Module: button_pulse_conditioner
// PURPOSE
//   Turns one raw push-button input into a debounced level and a single-cycle pulse per press.
//   Sits directly upstream of the FIFO; its pulse_o drives one FIFO enable (one instance for rd, one for wr).
//   One stage replaces the divider/debouncer/edge-detect chain. Guarantees exactly one FIFO operation per physical press.
// PARAMETERS
//   SYNC_STAGES      2          synchroniser flops on button_i (>=2)
//   DEBOUNCE_CYCLES  1_000_000  clk cycles input must be stable to accept a change (10 ms @ 100 MHz, >=1)
//   REPEAT_DELAY     50_000_000 cycles held in PRESSED before first auto-repeat pulse (AUTO_REPEAT_EN only)
//   REPEAT_PERIOD    10_000_000 cycles between subsequent auto-repeat pulses (AUTO_REPEAT_EN only)
// PORTS
//   clk       in   1  system clock
//   rst       in   1  asynchronous, active-low reset
//   button_i  in   1  raw, asynchronous button level (1 = pressed)
//   level_o   out  1  debounced button level
//   pulse_o   out  1  one-clk-wide press pulse -> FIFO rd/wr enable
// BEHAVIOUR
//   Interface: one clock (clk); reset rst is asynchronous and active-low.
//   Reset (rst=0, async): sync chain=0, state=IDLE, counters=0, level_o=0, pulse_o=0.
//   Sync: button_i -> SYNC_STAGES flops -> btn_s. Only btn_s is used by the FSM.
//   Debounce counter cnt: width $clog2(DEBOUNCE_CYCLES+1). Cleared on every state change; increments by 1 otherwise. Never wraps.
//   FSM (all transitions on posedge clk):
//     IDLE         btn_s=1 -> PRESS_WAIT (cnt=0); else stay.
//     PRESS_WAIT   btn_s=0 -> IDLE (bounce, no output).
//                  btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED. pulse_o=1 for that one cycle; level_o=1.
//                  else cnt++.
//     PRESSED      btn_s=0 -> RELEASE_WAIT (cnt=0); else stay.
//     RELEASE_WAIT btn_s=1 -> PRESSED (bounce on release, NO new pulse).
//                  btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; level_o=0.
//                  else cnt++.
//   Outputs are registered. level_o=1 in PRESSED and RELEASE_WAIT; 0 in IDLE and PRESS_WAIT.
//   pulse_o is high only on the cycle after the PRESS_WAIT->PRESSED edge.
//   pulse_o is never high for 2 consecutive cycles.
//   Latency: button_i stable high -> pulse_o high after SYNC_STAGES+1+DEBOUNCE_CYCLES clk edges.
//   Release latency is the same: button_i stable low -> level_o low after the same count.
//   Release never produces a pulse.
//   Glitch shorter than DEBOUNCE_CYCLES: no pulse_o and no level_o change.
//   Reset mid-press: state returns to IDLE. If the button is still held after rst=1, a full debounce runs again.
//     Exactly one pulse is produced for that hold.
// CONFIGURATION
//   `define AUTO_REPEAT_EN
//     Adds repeat counter rcnt, cleared on entry to PRESSED (from either source state) and in all other states.
//     In PRESSED, when rcnt reaches REPEAT_DELAY-1, pulse_o=1 for one cycle.
//     After that, a further one-cycle pulse is produced every REPEAT_PERIOD cycles while the state stays PRESSED.
//     A RELEASE_WAIT bounce restarts the REPEAT_DELAY window.
//   Without the macro: no rcnt logic. REPEAT_* parameters are unused. Exactly one pulse per accepted press.
// TESTING (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, REPEAT_DELAY=8, REPEAT_PERIOD=3)
//   1. Clean press: button_i 0->1 at cycle 0, held.
//      -> pulse_o=1 only at cycle 7, level_o 1 from cycle 7. Release after 20 cycles -> level_o 0 seven cycles later, no pulse.
//   2. Bounce: button_i high for 2 cycles, low 2, high 3, low.
//      -> pulse_o and level_o stay 0 throughout.
//   3. Release bounce: while PRESSED, button_i low 2 cycles then high again.
//      -> level_o stays 1 and no second pulse.
//   4. Async reset mid-press: assert rst=0 at cycle 10 of a hold (between clk edges), deassert at cycle 12, button still held.
//      -> outputs 0 immediately, pulse_o=1 exactly once at cycle 19.
//   5. Back-to-back presses: two clean 10-cycle presses separated by 10 low cycles.
//      -> exactly 2 pulse_o cycles; the FIFO count rises by 2.
//   6. AUTO_REPEAT_EN, hold 20 cycles after the first pulse.
//      -> further pulses 8, 11, 14, 17 cycles after the first.
//      Without the macro: only the first pulse.

Source files
------------

// File: rtl/button_pulse_conditioner_if.sv
// button_pulse_conditioner_if: raw button in, debounced level and press pulse out.
interface button_pulse_conditioner_if;
    logic button_i;
    logic level_o;
    logic pulse_o;
    modport master (output button_i, input level_o, input pulse_o);
    modport slave (input button_i, output level_o, output pulse_o);
endinterface

// File: rtl/button_pulse_conditioner.sv
// button_pulse_conditioner: synchronise, debounce and edge-detect one push button into level + single pulse.
// Define AUTO_REPEAT_EN to emit repeat pulses while the button stays held.
module button_pulse_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 50_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input logic clk,
    input logic rst,
    button_pulse_conditioner_if.slave btn
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("button_pulse_conditioner: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0] state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic level_q, level_d, pulse_q, pulse_d;
    logic btn_s, cnt_done, press_pulse;

    assign btn_s = sync_q[SYNC_STAGES-1];
    assign cnt_done = cnt_q == CW'(DEBOUNCE_CYCLES - 1);

    always_comb begin
        state_d = state_q == IDLE       ? (btn_s ? PRESS_WAIT : IDLE) :
                  state_q == PRESS_WAIT ? (!btn_s ? IDLE : cnt_done ? PRESSED : PRESS_WAIT) :
                  state_q == PRESSED    ? (btn_s ? PRESSED : RELEASE_WAIT) :
                                          (btn_s ? PRESSED : cnt_done ? IDLE : RELEASE_WAIT);
        cnt_d = state_d != state_q ? '0 : cnt_q == CW'(DEBOUNCE_CYCLES) ? cnt_q : cnt_q + CW'(1);
        press_pulse = state_q == PRESS_WAIT && state_d == PRESSED;
        level_d = state_d == PRESSED || state_d == RELEASE_WAIT;
    end

`ifdef AUTO_REPEAT_EN
    localparam int RMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAX + 1);
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic rep_q, rep_d, staying, rep_hit;
    // rep_q selects the first-repeat delay versus the steady repeat period
    always_comb begin
        staying = state_q == PRESSED && state_d == PRESSED;
        rep_hit = staying && rcnt_q == (rep_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1));
        rcnt_d = staying && !rep_hit ? rcnt_q + RW'(1) : '0;
        rep_d = staying && (rep_q || rep_hit);
        pulse_d = press_pulse || rep_hit;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rcnt_q <= '0;
            rep_q <= 1'b0;
        end else begin
            rcnt_q <= rcnt_d;
            rep_q <= rep_d;
        end
    end
`else
    assign pulse_d = press_pulse;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            state_q <= IDLE;
            cnt_q <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn.button_i};
            state_q <= state_d;
            cnt_q <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign btn.level_o = level_q;
    assign btn.pulse_o = pulse_q;
endmodule

// File: tb/tb_button_pulse_conditioner.sv
// tb_button_pulse_conditioner: directed scenarios plus random button traffic against a run-length model.
module tb_button_pulse_conditioner;
    localparam int S = 2, D = 4, RD = 8, RP = 3;
`ifdef AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b0;
    int n_cmp = 0, n_err = 0;
    int cyc, lvl_chg, fifo_cnt = 0;
    int pq[$];
    logic lvl_ref, prev_pulse = 1'b0;

    button_pulse_conditioner_if bif();
    button_pulse_conditioner #(.SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
        dut (.clk(clk), .rst(rst), .btn(bif));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Model: a change is accepted once the synced input has disagreed with the accepted level for D+1 samples.
    logic [S-1:0] m_sh;
    logic m_acc, m_pulse;
    int m_run, m_hold;
    wire m_s = m_sh[S-1];
    wire m_accept = m_s != m_acc && m_run == D;
    wire m_rep = m_acc && m_s && (m_hold + 1 >= RD) && ((m_hold + 1 - RD) % RP == 0);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_sh <= '0;
            m_acc <= 1'b0;
            m_run <= 0;
            m_hold <= 0;
            m_pulse <= 1'b0;
        end else begin
            m_sh <= {m_sh[S-2:0], bif.button_i};
            m_run <= (m_s != m_acc && !m_accept) ? m_run + 1 : 0;
            m_acc <= m_accept ? m_s : m_acc;
            m_hold <= (m_acc && m_s) ? m_hold + 1 : 0;
            m_pulse <= (m_accept && m_s) || (AR && m_rep);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_level", bif.level_o, 0);
            check("rst_pulse", bif.pulse_o, 0);
        end else begin
            check("pulse", bif.pulse_o, m_pulse);
            check("level", bif.level_o, m_acc);
            check("no_double", prev_pulse && bif.pulse_o, 0);
            if (bif.pulse_o) fifo_cnt++;
        end
        prev_pulse = bif.pulse_o;
    end

    task automatic mark();
        cyc = 0;
        pq.delete();
        lvl_ref = bif.level_o;
        lvl_chg = -1;
    endtask

    task automatic step(input logic b, input int n);
        bif.button_i = b;
        repeat (n) begin
            @(negedge clk);
            cyc++;
            if (bif.pulse_o) pq.push_back(cyc);
            if (bif.level_o !== lvl_ref && lvl_chg < 0) lvl_chg = cyc;
        end
    endtask

    int exp_q[$];
    int f0;

    initial begin
        bif.button_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        mark();
        step(0, 5);
        // clean press and release
        mark(); step(1, 12);
        check("t1_npulse", pq.size(), 1);
        check("t1_pcyc", pq[0], 7);
        check("t1_lvl_on", lvl_chg, 7);
        mark(); step(0, 12);
        check("t1_rel_npulse", pq.size(), 0);
        check("t1_lvl_off", lvl_chg, 7);
        // press bounce
        mark(); step(1, 2); step(0, 2); step(1, 3); step(0, 10);
        check("t2_npulse", pq.size(), 0);
        check("t2_lvl", lvl_chg, -1);
        // release bounce
        mark(); step(1, 10);
        check("t3_npulse", pq.size(), 1);
        mark(); step(0, 2); step(1, 10);
        check("t3_bounce_npulse", pq.size(), 0);
        check("t3_bounce_lvl", lvl_chg, -1);
        mark(); step(0, 12);
        check("t3_rel_lvl", lvl_chg, 7);
        // async reset mid-press
        mark(); step(1, 10);
        #2 rst = 1'b0;
        #1 check("t4_lvl_async", bif.level_o, 0);
        check("t4_pulse_async", bif.pulse_o, 0);
        @(negedge clk); @(negedge clk);
        #2 rst = 1'b1;
        cyc = 12; pq.delete();
        step(1, 10);
        check("t4_npulse", pq.size(), 1);
        check("t4_pcyc", pq[0], 19);
        mark(); step(0, 12);
        // back-to-back presses
        f0 = fifo_cnt;
        mark(); step(1, 10); step(0, 10); step(1, 10); step(0, 12);
        check("t5_npulse", pq.size(), 2);
        check("t5_fifo", fifo_cnt - f0, 2);
        // long hold: auto-repeat pulses only when enabled
        mark(); step(1, 27);
        if (AR) exp_q = '{7, 15, 18, 21, 24, 27};
        else exp_q = '{7};
        check("t6_npulse", pq.size(), exp_q.size());
        foreach (exp_q[i]) check("t6_pcyc", pq[i], exp_q[i]);
        mark(); step(0, 12);
        check("t6_rel_npulse", pq.size(), 0);
        // random traffic with occasional async resets
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(1, 9));
            if ($urandom_range(0, 40) == 0) begin
                #2 rst = 1'b0;
                @(negedge clk);
                #2 rst = 1'b1;
            end
        end
        step(0, 12);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
